// File: rtl/simon_host_driver_if.sv
// Host-side word stream of the SIMON driver: input words with group tags,
// the result word stream and the error pulse.
interface simon_host_driver_if #(
  parameter int W = 32
);
  logic [W-1:0] in_word;
  logic         in_valid;
  logic         in_key;
  logic         in_dec;
  logic         in_ready;
  logic [W-1:0] out_word;
  logic         out_valid;
  logic         out_ready;
  logic         err;

  modport master (
    output in_word, in_valid, in_key, in_dec, out_ready,
    input  in_ready, out_word, out_valid, err
  );

  modport slave (
    input  in_word, in_valid, in_key, in_dec, out_ready,
    output in_ready, out_word, out_valid, err
  );
endinterface

// File: rtl/simon_host_driver.sv
// Assembles host words into SIMON key / plaintext blocks, sequences the core
// handshake and streams the cipher block back to the host, LS word first.
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | waiting for the first word of a group
// COLLECT   | accepting the remaining words of a group
// KEY_REQ   | newKey high, waiting for ldKey
// KEY_WAIT  | core expanding key, waiting for doneKey
// DATA_REQ  | newData high, waiting for ldData
// DATA_WAIT | core running, waiting for doneData
// READ      | capture cipher, readData pulse
// EMIT      | presenting buffered result words to the host
module simon_host_driver #(
  parameter int N = 64,
  parameter int M = 2,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 R,
  simon_host_driver_if.slave   host,
  output logic                 newData,
  output logic                 newKey,
  output logic                 enc_dec,
  output logic                 readData,
  output logic [2*N-1:0]       plain,
  output logic [M*N-1:0]       key,
  input  logic                 ldData,
  input  logic                 ldKey,
  input  logic                 doneData,
  input  logic                 doneKey,
  input  logic [2*N-1:0]       cipher
);

  localparam int BW   = 2 * N;
  localparam int KB   = M * N;
  localparam int KW   = KB / W;
  localparam int DW   = BW / W;
  localparam int GMAX = (KW > DW) ? KW : DW;
  localparam int CW   = $clog2(GMAX + 1);

  typedef enum logic [2:0] {
    IDLE, COLLECT, KEY_REQ, KEY_WAIT, DATA_REQ, DATA_WAIT, READ, EMIT
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            grp_key;
  logic            key_valid;
  logic            err_q;
  logic [BW-1:0]   obuf;
  logic [BW-1:0]   plain_shift;
  logic [KB-1:0]   key_shift;
  logic            accept, take, give;
  logic            key_now, last_in, last_out;

  // Group type is taken from in_key on the first word only, then latched.
  assign accept   = !R && (state == IDLE || state == COLLECT);
  assign take     = host.in_valid && accept;
  assign give     = host.out_ready && (state == EMIT);
  assign key_now  = (state == IDLE) ? host.in_key : grp_key;
  assign last_in  = key_now ? (cnt == CW'(KW - 1)) : (cnt == CW'(DW - 1));
  assign last_out = (cnt == CW'(DW - 1));

  assign host.in_ready  = accept;
  assign host.out_valid = (state == EMIT);
  assign host.out_word  = (state == EMIT) ? obuf[W-1:0] : '0;
  assign host.err       = err_q;

  // New words enter at the top so the first word ends up least significant.
  always_comb begin
    key_shift              = key >> W;
    key_shift[KB-1 -: W]   = host.in_word;
    plain_shift            = plain >> W;
    plain_shift[BW-1 -: W] = host.in_word;
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) state <= IDLE;
    else   state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    newKey   = 1'b0;
    newData  = 1'b0;
    readData = 1'b0;
    unique case (state)
      IDLE, COLLECT: begin
        if (take) begin
          if (!last_in)       state_nx = COLLECT;
          else if (key_now)   state_nx = KEY_REQ;
          else if (key_valid) state_nx = DATA_REQ;
          else                state_nx = IDLE;
        end
      end
      KEY_REQ: begin
        newKey = 1'b1;
        if (ldKey) state_nx = KEY_WAIT;
      end
      KEY_WAIT:  if (doneKey) state_nx = IDLE;
      DATA_REQ: begin
        newData = 1'b1;
        if (ldData) state_nx = DATA_WAIT;
      end
      DATA_WAIT: if (doneData) state_nx = READ;
      READ: begin
        readData = 1'b1;
        state_nx = EMIT;
      end
      EMIT:      if (give && last_out) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      cnt       <= '0;
      grp_key   <= 1'b0;
      enc_dec   <= 1'b0;
      key_valid <= 1'b0;
      err_q     <= 1'b0;
      plain     <= '0;
      key       <= '0;
      obuf      <= '0;
    end else begin
      err_q <= 1'b0;
      if (take) begin
        if (state == IDLE) begin
          grp_key <= host.in_key;
          enc_dec <= host.in_dec;
        end
        if (key_now) key   <= key_shift;
        else         plain <= plain_shift;
        cnt <= last_in ? '0 : cnt + CW'(1);
        if (last_in && key_now)                err_q     <= 1'b0;
        if (last_in && key_now)                key_valid <= 1'b0;
        if (last_in && !key_now && !key_valid) err_q     <= 1'b1;
      end
      if (state == KEY_WAIT && doneKey) key_valid <= 1'b1;
      if (state == READ) obuf <= cipher;
      if (give) begin
        obuf <= obuf >> W;
        cnt  <= last_out ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_simon_host_driver.sv
// Bench for simon_host_driver: vector table, hand-written corner sequences and
// a randomized phase, all against a behavioural SIMON core and block model.
module tb_simon_host_driver;

  localparam int N  = 64;
  localparam int M  = 2;
  localparam int W  = 32;
  localparam int NW = 4;

  localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] KAT_PT  = 128'h63736564_20737265_6c6c6576_61727420;
  localparam logic [127:0] KAT_CT  = 128'h49681b1e_1e54fe3f_65aa832a_f84e0bbc;
  localparam logic [127:0] K2      = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  logic         clk = 1'b0;
  logic         R;
  logic         newData, newKey, enc_dec, readData;
  logic [127:0] plain, key, cipher;
  logic         ldData, ldKey, doneData, doneKey;

  simon_host_driver_if #(.W(W)) hif();

  simon_host_driver #(.N(N), .M(M), .W(W)) dut (
    .clk(clk), .R(R), .host(hif),
    .newData(newData), .newKey(newKey), .enc_dec(enc_dec), .readData(readData),
    .plain(plain), .key(key),
    .ldData(ldData), .ldKey(ldKey), .doneData(doneData), .doneKey(doneKey),
    .cipher(cipher)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int nd_cnt = 0, rd_cnt = 0, cyc = 0;
  int ld_dly = 0, done_dly = 0;
  int spur_req = 0, spur_done = 0;
  logic chk_hold = 1'b0;
  logic [127:0] cur_plain = '0;
  logic [127:0] m_key = '0;
  logic m_kv = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Behavioural core: the published SIMON128/128 pair, otherwise an invertible mix.
  function automatic logic [127:0] core_fn(input logic dec, input logic [127:0] p, input logic [127:0] k);
    logic [127:0] t;
    if (k == KAT_KEY && !dec && p == KAT_PT) return KAT_CT;
    if (k == KAT_KEY &&  dec && p == KAT_CT) return KAT_PT;
    if (!dec) return {p[63:0], p[127:64]} ^ k;
    t = p ^ k;
    return {t[63:0], t[127:64]};
  endfunction

  always @(negedge clk) begin
    if (newData)  nd_cnt <= nd_cnt + 1;
    if (readData) rd_cnt <= rd_cnt + 1;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : core_model
    logic         c_dec;
    logic [127:0] c_p, c_k;
    ldData = 0; ldKey = 0; doneData = 0; doneKey = 0; cipher = '0;
    forever begin
      @(posedge clk); #1;
      if (spur_req != spur_done) begin
        ldData = 1; ldKey = 1; doneData = 1; doneKey = 1;
        @(posedge clk); #1;
        ldData = 0; ldKey = 0; doneData = 0; doneKey = 0;
        spur_done = spur_req;
      end else if (!R && newKey) begin
        repeat (ld_dly) begin @(posedge clk); #1; end
        ldKey = 1; @(posedge clk); #1; ldKey = 0;
        repeat (done_dly) begin @(posedge clk); #1; end
        doneKey = 1; @(posedge clk); #1; doneKey = 0;
      end else if (!R && newData) begin
        repeat (ld_dly) begin
          if (chk_hold) begin
            check("newdata_held", newData, 1'b1);
            check("plain_held_req", plain, cur_plain);
          end
          @(posedge clk); #1;
        end
        c_dec = enc_dec; c_p = plain; c_k = key;
        ldData = 1; @(posedge clk); #1; ldData = 0;
        repeat (done_dly) begin
          if (chk_hold) check("plain_held_wait", plain, cur_plain);
          @(posedge clk); #1;
        end
        cipher = core_fn(c_dec, c_p, c_k);
        doneData = 1; @(posedge clk); #1; doneData = 0;
      end
    end
  end

  task automatic send_group(input logic is_key, input logic dec, input logic [127:0] val);
    int budget;
    for (int i = 0; i < NW; i++) begin
      hif.in_word  = val[i*W +: W];
      hif.in_valid = 1'b1;
      hif.in_key   = (i == 0) ? is_key : 1'($urandom);
      hif.in_dec   = (i == 0) ? dec    : 1'($urandom);
      budget = 2000;
      @(negedge clk);
      while (!hif.in_ready && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (budget == 0) begin
        timeout_fail("in_ready");
        break;
      end
      @(posedge clk); #1;
    end
    hif.in_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: hold off word 1 for five cycles
  task automatic collect_out(input int mode, input logic [127:0] exp, input string tag);
    int k, budget, stall, last_cyc;
    k = 0; budget = 3000; stall = 5; last_cyc = 0;
    while (k < NW && budget > 0) begin
      case (mode)
        1: hif.out_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (hif.out_valid && k == 1 && stall > 0) begin
            hif.out_ready = 1'b0;
            stall--;
            check($sformatf("%s_stall_word", tag), hif.out_word, exp[W +: W]);
          end else hif.out_ready = 1'b1;
        end
        default: hif.out_ready = 1'b1;
      endcase
      @(negedge clk);
      if (hif.out_valid && hif.out_ready) begin
        check($sformatf("%s_w%0d", tag, k), hif.out_word, exp[k*W +: W]);
        if (mode == 0 && k > 0) check($sformatf("%s_gap%0d", tag, k), cyc - last_cyc, 1);
        last_cyc = cyc;
        k++;
      end
      @(posedge clk); #1;
      budget--;
    end
    if (k < NW) timeout_fail({tag, "_out"});
    hif.out_ready = 1'b1;
    check({tag, "_valid_low_after"}, hif.out_valid, 1'b0);
  endtask

  task automatic do_key(input logic [127:0] k, input string tag);
    send_group(1'b1, 1'($urandom), k);
    check({tag, "_newkey_first"}, newKey, 1'b1);
    m_key = k;
    m_kv  = 1'b1;
  endtask

  task automatic do_data(input logic dec, input logic [127:0] p, input logic exp_err,
                         input logic [127:0] exp, input int mode, input string tag);
    int nd0, rd0;
    nd0 = nd_cnt; rd0 = rd_cnt;
    cur_plain = p;
    send_group(1'b0, dec, p);
    if (exp_err) begin
      check({tag, "_err_pulse"}, hif.err, 1'b1);
      check({tag, "_in_ready_back"}, hif.in_ready, 1'b1);
      @(posedge clk); #1;
      check({tag, "_err_one_cycle"}, hif.err, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check({tag, "_no_newdata"}, nd_cnt - nd0, 0);
    end else begin
      check({tag, "_newdata_first"}, newData, 1'b1);
      collect_out(mode, exp, tag);
      check({tag, "_readdata_single"}, rd_cnt - rd0, 1);
    end
  endtask

  typedef struct {
    logic         is_key;
    logic         dec;
    logic [127:0] val;
    logic         exp_err;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[7];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [127:0] p;
    logic         d;
    int           nd0;

    tbl[0] = '{is_key: 1'b0, dec: 1'b0, val: KAT_PT, exp_err: 1'b1, exp: '0};
    tbl[1] = '{is_key: 1'b1, dec: 1'b0, val: KAT_KEY, exp_err: 1'b0, exp: '0};
    tbl[2] = '{is_key: 1'b0, dec: 1'b0, val: KAT_PT, exp_err: 1'b0, exp: KAT_CT};
    tbl[3] = '{is_key: 1'b0, dec: 1'b1, val: KAT_CT, exp_err: 1'b0, exp: KAT_PT};
    tbl[4] = '{is_key: 1'b1, dec: 1'b1, val: K2, exp_err: 1'b0, exp: '0};
    tbl[5] = '{is_key: 1'b0, dec: 1'b0, val: '0, exp_err: 1'b0, exp: K2};
    tbl[6] = '{is_key: 1'b0, dec: 1'b1, val: K2, exp_err: 1'b0, exp: '0};

    hif.in_word = '0; hif.in_valid = 0; hif.in_key = 0; hif.in_dec = 0; hif.out_ready = 1;
    R = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {hif.in_ready, hif.out_valid, hif.err, newData, newKey, readData, enc_dec}, 7'b0);
    check("reset_plain", plain, 128'h0);
    check("reset_key", key, 128'h0);
    check("reset_out_word", hif.out_word, 32'h0);
    R = 1'b0;
    #1;
    check("in_ready_after_reset", hif.in_ready, 1'b1);

    // stray core strobes while idle must not move the FSM or validate a key
    spur_req++;
    repeat (4) @(posedge clk);
    #1;
    check("spur_idle", {hif.in_ready, hif.out_valid, newData, newKey, readData}, 5'b10000);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].is_key) do_key(tbl[i].val, $sformatf("tbl%0d", i));
      else do_data(tbl[i].dec, tbl[i].val, tbl[i].exp_err, tbl[i].exp, 0, $sformatf("tbl%0d", i));
    end

    // slow core: newData must hold through the ldData delay, plain held throughout
    ld_dly = 10; done_dly = 50; chk_hold = 1'b1;
    p = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    nd0 = nd_cnt;
    do_data(1'b0, p, 1'b0, core_fn(1'b0, p, m_key), 0, "slow");
    check("slow_newdata_cycles", nd_cnt - nd0, 11);
    chk_hold = 1'b0; ld_dly = 0; done_dly = 0;

    p = 128'h1357_9bdf_2468_ace0_0f1e_2d3c_4b5a_6978;
    do_data(1'b1, p, 1'b0, core_fn(1'b1, p, m_key), 2, "stall");

    for (int i = 0; i < 25; i++) begin
      ld_dly = $urandom_range(0, 3);
      done_dly = $urandom_range(0, 3);
      if (i == 0 || $urandom_range(0, 3) == 0) begin
        do_key({$urandom, $urandom, $urandom, $urandom}, $sformatf("rk%0d", i));
      end else begin
        p = {$urandom, $urandom, $urandom, $urandom};
        d = 1'($urandom);
        do_data(d, p, !m_kv, core_fn(d, p, m_key), $urandom_range(0, 1), $sformatf("rd%0d", i));
      end
    end
    ld_dly = 0;

    // reset while the core is busy; the key must be forgotten
    done_dly = 40;
    do_key(KAT_KEY, "rst_key");
    cur_plain = KAT_CT;
    send_group(1'b0, 1'b1, KAT_CT);
    repeat (5) @(posedge clk);
    #2;
    R = 1'b1;
    #1;
    check("midreset_ctrl", {hif.in_ready, hif.out_valid, hif.err, newData, newKey, readData, enc_dec}, 7'b0);
    check("midreset_plain", plain, 128'h0);
    check("midreset_key", key, 128'h0);
    check("midreset_out_word", hif.out_word, 32'h0);
    @(posedge clk); #1;
    R = 1'b0;
    m_kv = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    done_dly = 0;
    do_data(1'b0, KAT_PT, 1'b1, '0, 0, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/simon_host_driver.md
SIMON_HOST_DRIVER -- requirements
Module: simon_host_driver

Interface
REQ-001 SHALL have parameter N, default 64, cipher word width in bits.
REQ-002 SHALL have parameter M, default 2, number of key words.
REQ-003 SHALL have parameter W, default 32, host word width in bits; 2*N and M*N SHALL be multiples of W.
REQ-004 clk  input  1  single clock; all flops on rising edge.
REQ-005 R  input  1  reset, asynchronous, active-high.
REQ-006 in_word  input  W  host input word.
REQ-007 in_valid  input  1  in_word valid.
REQ-008 in_key  input  1  1 = word belongs to a key group, 0 = data group.
REQ-009 in_dec  input  1  1 = decrypt, 0 = encrypt.
REQ-010 in_ready  output  1  driver accepts in_word this cycle.
REQ-011 out_word  output  W  result word.
REQ-012 out_valid  output  1  out_word valid.
REQ-013 out_ready  input  1  host accepts out_word.
REQ-014 err  output  1  one-cycle pulse: data group discarded because no key is loaded.
REQ-015 Core-side outputs: newData 1, newKey 1, enc_dec 1, readData 1, plain 2*N, key M*N.
REQ-016 Core-side inputs: ldData 1, ldKey 1, doneData 1, doneKey 1, cipher 2*N.

Function
REQ-017 Host transfer SHALL occur on any clock edge where in_valid and in_ready are both 1, or where out_valid and out_ready are both 1.
REQ-018 Group size SHALL be M*N/W words for a key and 2*N/W words for data, least-significant word first.
REQ-019 in_key and in_dec SHALL be sampled on the first word of a group only; later values within the group SHALL be ignored.
REQ-020 FSM states SHALL be: IDLE, COLLECT, KEY_REQ, KEY_WAIT, DATA_REQ, DATA_WAIT, READ, EMIT.
REQ-021 in_ready SHALL be 1 only in IDLE and COLLECT.
REQ-022 Transitions:
- IDLE -> COLLECT on first word.
- COLLECT -> KEY_REQ or DATA_REQ on the final word of the group.
- KEY_REQ -> KEY_WAIT on ldKey; KEY_WAIT -> IDLE on doneKey.
- DATA_REQ -> DATA_WAIT on ldData; DATA_WAIT -> READ on doneData.
- READ -> EMIT after one cycle; EMIT -> IDLE after the last word is accepted.
REQ-023 newKey SHALL be 1 throughout KEY_REQ; newData SHALL be 1 throughout DATA_REQ; both SHALL be 0 in every other state.
REQ-024 The first newKey or newData cycle SHALL be the cycle after the final word is accepted.
REQ-025 key, plain and enc_dec SHALL hold stable from entry to REQ until the driver returns to IDLE.
REQ-026 A keyValid flag SHALL:
- set on doneKey in KEY_WAIT;
- clear on entry to KEY_REQ;
- clear on reset.
REQ-027 Data group with keyValid=0: on the final word, the driver SHALL pulse err for one cycle, discard the block and return to IDLE without asserting newData.
REQ-028 READ SHALL capture cipher into the output buffer and pulse readData for exactly one cycle.
REQ-029 EMIT SHALL present buffered words least-significant first, holding out_word and out_valid stable until accepted.
REQ-030 out_valid SHALL be 0 outside EMIT.
REQ-031 Zero-wait host: output word k+1 SHALL follow word k on the next cycle.
REQ-032 ldKey or ldData arriving in an unexpected state SHALL be ignored.
REQ-033 doneData arriving outside DATA_WAIT SHALL be ignored.
REQ-034 A key group SHALL be accepted while keyValid=1 and SHALL replace the key.

Reset
REQ-035 On R=1 the driver SHALL asynchronously enter IDLE and clear the word counter and keyValid.
REQ-036 On R=1 all outputs SHALL be 0: in_ready, out_valid, err, newData, newKey, readData, enc_dec, plain, key, out_word.
REQ-037 Reset mid-operation SHALL discard any partial group and buffered result.
REQ-038 The first word after reset release SHALL start a new group.

Verification
REQ-039 Known-answer test, bench uses a real or behavioural core:
- key words 03020100, 07060504, 0b0a0908, 0f0e0d0c, then plain words 61727420, 6c6c6576, 20737265, 63736564, enc.
- Required out words: f84e0bbc, 65aa832a, 1e54fe3f, 49681b1e.
REQ-040 Decrypt the REQ-039 ciphertext with in_dec=1 -> plaintext words of REQ-039 returned.
REQ-041 Data group sent first after reset -> err pulses one cycle after the 4th word; newData never asserted; in_ready returns to 1.
REQ-042 Core delays ldData by 10 cycles and doneData by 50 cycles -> newData stays high for all 10 cycles; readData is a single pulse; plain is unchanged throughout.
REQ-043 out_ready=0 for 5 cycles on word 2 -> out_word is stable for those cycles; no word is lost or duplicated.
REQ-044 R asserted in DATA_WAIT -> all outputs are 0 immediately; the next data group raises err because keyValid is cleared.
